// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage: memory-access pipeline stage.
//
// Takes one instruction from execute. Non-memory instructions pass straight
// through with 1-cycle latency. Loads and stores drive a req/gnt/rvalid data
// bus with a single outstanding access. The stage stalls the pipeline until
// the access retires. Results are registered towards writeback.
//
// Ports
//   clk, rst_n             pipeline clock, asynchronous active-low reset
//   m_regfile_waddr_i      destination register
//   m_regfile_rd_i         ALU result, or store data for stores
//   m_regfile_wr_i         instruction writes the register file
//   m_data_wr_i/rd_i       store / load
//   m_data_addr_i          byte address of the access
//   m_data_be_i            access size: 00 byte, 01 half, 10 word
//   m_is_load_store_i      instruction is a memory access
//   m_LOAD_op_i            000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
//   data_*                 data bus (req/gnt handshake, rvalid response)
//   w_regfile_*_o          registered writeback outputs
//   stall_mem_o            stall request, ORed into the global stall
//   misalign_o             one-cycle pulse on a rejected misaligned access
//
// Build option
//   MEM_MISALIGN_CHECK_EN  when defined, a misaligned half or word access
//                          retires immediately with no bus request and no
//                          register write, and pulses misalign_o. When it is
//                          undefined, the low address bits below the access
//                          size are ignored.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module mem_stage (
  input  logic        clk,
  input  logic        rst_n,
  // from execute
  input  logic [4:0]  m_regfile_waddr_i,
  input  logic [31:0] m_regfile_rd_i,
  input  logic        m_regfile_wr_i,
  input  logic        m_data_wr_i,
  input  logic        m_data_rd_i,
  input  logic [31:0] m_data_addr_i,
  input  logic [1:0]  m_data_be_i,
  input  logic        m_is_load_store_i,
  input  logic [2:0]  m_LOAD_op_i,
  // data bus
  output logic        data_req_o,
  input  logic        data_gnt_i,
  input  logic        data_rvalid_i,
  output logic [31:0] data_addr_o,
  output logic        data_we_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_wdata_o,
  input  logic [31:0] data_rdata_i,
  // to writeback / hazard unit
  output logic [4:0]  w_regfile_waddr_o,
  output logic [31:0] w_regfile_wd_o,
  output logic        w_regfile_wr_o,
  output logic        stall_mem_o,
  output logic        misalign_o
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StReq  = 2'd1;
  localparam logic [1:0] StWait = 2'd2;

  logic [1:0]  state_q, state_d;
  logic        pending;
  logic        misalign_now;
  logic        is_store;
  logic        is_load;
  logic        req;
  logic        retire;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] load_data;

  logic [4:0]  waddr_q;
  logic [31:0] wd_q;
  logic        wr_q;

  assign pending  = m_is_load_store_i & (m_data_rd_i | m_data_wr_i);
  assign is_store = pending & m_data_wr_i;
  assign is_load  = pending & ~m_data_wr_i & ~misalign_now;

`ifdef MEM_MISALIGN_CHECK_EN
  logic misalign_q;

  // Only checked on entry; a rejected access never leaves StIdle.
  assign misalign_now = pending & (state_q == StIdle) &
                        (((m_data_be_i == 2'b01) & m_data_addr_i[0]) |
                         (m_data_be_i[1] & (m_data_addr_i[1:0] != 2'b00)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= misalign_now;
    end
  end

  assign misalign_o = misalign_q;
`else
  assign misalign_now = 1'b0;
  assign misalign_o   = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Bus request FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    req     = 1'b0;
    retire  = 1'b0;
    case (state_q)
      StIdle: begin
        if (!pending || misalign_now) begin
          retire = 1'b1;
        end else begin
          req = 1'b1;
          if (data_gnt_i) begin
            // A granted store is done; a granted load waits for its data.
            if (is_store) begin
              retire = 1'b1;
            end else begin
              state_d = StWait;
            end
          end else begin
            state_d = StReq;
          end
        end
      end
      StReq: begin
        req = 1'b1;
        if (data_gnt_i) begin
          if (is_store) begin
            retire  = 1'b1;
            state_d = StIdle;
          end else begin
            state_d = StWait;
          end
        end
      end
      StWait: begin
        if (data_rvalid_i) begin
          retire  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Combinational outputs are gated by reset so that an instruction held at
  // the stage input cannot request the bus or stall the pipe while in reset.
  assign data_req_o  = rst_n & req;
  assign stall_mem_o = rst_n & pending & ~retire;

  // ---------------------------------------------------------------------------
  // Request formatting
  // ---------------------------------------------------------------------------
  assign data_addr_o = {m_data_addr_i[31:2], 2'b00};
  assign data_we_o   = m_data_wr_i;

  always_comb begin
    data_be_o    = 4'b1111;
    data_wdata_o = m_regfile_rd_i;
    case (m_data_be_i)
      2'b00: begin
        data_be_o    = 4'b0001 << m_data_addr_i[1:0];
        data_wdata_o = {4{m_regfile_rd_i[7:0]}};
      end
      2'b01: begin
        data_be_o    = 4'b0011 << {m_data_addr_i[1], 1'b0};
        data_wdata_o = {2{m_regfile_rd_i[15:0]}};
      end
      default: begin
        data_be_o    = 4'b1111;
        data_wdata_o = m_regfile_rd_i;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Load data alignment and extension
  // ---------------------------------------------------------------------------
  always_comb begin
    case (m_data_addr_i[1:0])
      2'b00:   ld_byte = data_rdata_i[7:0];
      2'b01:   ld_byte = data_rdata_i[15:8];
      2'b10:   ld_byte = data_rdata_i[23:16];
      default: ld_byte = data_rdata_i[31:24];
    endcase
  end

  // Halfword lane follows the byte enables, which ignore addr[0].
  assign ld_half = m_data_addr_i[1] ? data_rdata_i[31:16] : data_rdata_i[15:0];

  always_comb begin
    case (m_LOAD_op_i)
      3'b000:  load_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  load_data = {{16{ld_half[15]}}, ld_half};
      3'b100:  load_data = {24'h0, ld_byte};
      3'b101:  load_data = {16'h0, ld_half};
      default: load_data = data_rdata_i;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Writeback registers: updated on retire, bubble (wr=0) otherwise.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      waddr_q <= 5'd0;
      wd_q    <= 32'd0;
      wr_q    <= 1'b0;
    end else if (retire) begin
      waddr_q <= m_regfile_waddr_i;
      wd_q    <= is_load ? load_data : m_regfile_rd_i;
      wr_q    <= m_regfile_wr_i & ~is_store & ~misalign_now;
    end else begin
      wr_q    <= 1'b0;
    end
  end

  assign w_regfile_waddr_o = waddr_q;
  assign w_regfile_wd_o    = wd_q;
  assign w_regfile_wr_o    = wr_q;

endmodule

// File: tb/tb_mem_stage.sv
`timescale 1ns/1ps
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  m_regfile_waddr_i;
  logic [31:0] m_regfile_rd_i;
  logic        m_regfile_wr_i;
  logic        m_data_wr_i;
  logic        m_data_rd_i;
  logic [31:0] m_data_addr_i;
  logic [1:0]  m_data_be_i;
  logic        m_is_load_store_i;
  logic [2:0]  m_LOAD_op_i;
  logic        data_req_o;
  logic        data_gnt_i;
  logic        data_rvalid_i;
  logic [31:0] data_addr_o;
  logic        data_we_o;
  logic [3:0]  data_be_o;
  logic [31:0] data_wdata_o;
  logic [31:0] data_rdata_i;
  logic [4:0]  w_regfile_waddr_o;
  logic [31:0] w_regfile_wd_o;
  logic        w_regfile_wr_o;
  logic        stall_mem_o;
  logic        misalign_o;

  mem_stage dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .m_regfile_waddr_i (m_regfile_waddr_i),
    .m_regfile_rd_i    (m_regfile_rd_i),
    .m_regfile_wr_i    (m_regfile_wr_i),
    .m_data_wr_i       (m_data_wr_i),
    .m_data_rd_i       (m_data_rd_i),
    .m_data_addr_i     (m_data_addr_i),
    .m_data_be_i       (m_data_be_i),
    .m_is_load_store_i (m_is_load_store_i),
    .m_LOAD_op_i       (m_LOAD_op_i),
    .data_req_o        (data_req_o),
    .data_gnt_i        (data_gnt_i),
    .data_rvalid_i     (data_rvalid_i),
    .data_addr_o       (data_addr_o),
    .data_we_o         (data_we_o),
    .data_be_o         (data_be_o),
    .data_wdata_o      (data_wdata_o),
    .data_rdata_i      (data_rdata_i),
    .w_regfile_waddr_o (w_regfile_waddr_o),
    .w_regfile_wd_o    (w_regfile_wd_o),
    .w_regfile_wr_o    (w_regfile_wr_o),
    .stall_mem_o       (stall_mem_o),
    .misalign_o        (misalign_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_mem;
    bit          is_store;
    logic [2:0]  lop;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] rd;
    logic [31:0] rdata;
    logic [4:0]  waddr;
    bit          rwr;
    int          gnt_dly;
    int          rv_dly;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_wd;
    bit          exp_wr;
    bit          exp_mis;
    int          exp_stall;
    int          exp_req;
  } vec_t;

  typedef struct {
    logic [4:0]  waddr;
    logic [31:0] wd;
    logic        wr;
    logic        mis;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input bit mem, input bit st, input logic [2:0] lop,
                              input logic [1:0] sz, input logic [31:0] addr,
                              input logic [31:0] rd, input logic [31:0] rdata,
                              input logic [4:0] wa, input bit rwr, input int gd,
                              input int rvd, input logic [3:0] ebe,
                              input logic [31:0] ewdata, input logic [31:0] ewd,
                              input bit ewr, input bit emis, input int estall,
                              input int ereq);
    vec_t v;
    v.is_mem = mem; v.is_store = st; v.lop = lop; v.size = sz; v.addr = addr;
    v.rd = rd; v.rdata = rdata; v.waddr = wa; v.rwr = rwr; v.gnt_dly = gd;
    v.rv_dly = rvd; v.exp_be = ebe; v.exp_wdata = ewdata; v.exp_wd = ewd;
    v.exp_wr = ewr; v.exp_mis = emis; v.exp_stall = estall; v.exp_req = ereq;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    m_regfile_waddr_i = v.waddr;
    m_regfile_rd_i    = v.rd;
    m_regfile_wr_i    = v.rwr;
    m_data_wr_i       = v.is_mem & v.is_store;
    m_data_rd_i       = v.is_mem & !v.is_store;
    m_data_addr_i     = v.addr;
    m_data_be_i       = v.size;
    m_is_load_store_i = v.is_mem;
    m_LOAD_op_i       = v.lop;
    data_rdata_i      = v.rdata;
  endtask

  task automatic set_idle();
    m_is_load_store_i = 1'b0;
    m_data_wr_i       = 1'b0;
    m_data_rd_i       = 1'b0;
    m_regfile_wr_i    = 1'b0;
    m_regfile_rd_i    = 32'h0;
    data_gnt_i        = 1'b0;
    data_rvalid_i     = 1'b0;
  endtask

  // Called just after a rising edge. Plays the bus slave for one instruction,
  // then compares the registered writeback against the scoreboard.
  task automatic run_instr(input string tag, input vec_t v);
    int   cyc     = 0;
    int   stalls  = 0;
    int   reqs    = 0;
    int   gcyc    = 0;
    bit   granted = 0;
    bit   done    = 0;
    exp_t e;
    apply(v);
    e.waddr = v.waddr; e.wd = v.exp_wd; e.wr = v.exp_wr; e.mis = v.exp_mis;
    exp_q.push_back(e);
    while (!done && cyc < 50) begin
      data_gnt_i    = v.is_mem && !granted && (cyc >= v.gnt_dly);
      data_rvalid_i = granted && !v.is_store && (cyc == gcyc + 1 + v.rv_dly);
      @(negedge clk);
      if (cyc > 0) chk({tag, " bubble_wr"}, {31'b0, w_regfile_wr_o}, 32'd0);
      if (data_req_o) begin
        if (reqs == 0) begin
          chk({tag, " addr"}, data_addr_o, v.addr & 32'hFFFF_FFFC);
          chk({tag, " we"}, {31'b0, data_we_o}, {31'b0, v.is_store});
          chk({tag, " be"}, {28'b0, data_be_o}, {28'b0, v.exp_be});
          if (v.is_store) chk({tag, " wdata"}, data_wdata_o, v.exp_wdata);
        end
        reqs++;
        if (data_gnt_i) begin
          granted = 1;
          gcyc    = cyc;
        end
      end
      if (stall_mem_o) stalls++;
      else done = 1;
      @(posedge clk);
      #1;
      cyc++;
    end
    set_idle();
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s timeout: no retire after %0d cycles, expected retire", tag, cyc);
    end
    chk({tag, " stall_cycles"}, stalls, v.exp_stall);
    chk({tag, " req_cycles"}, reqs, v.exp_req);
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s scoreboard: empty queue, expected an entry", tag);
    end else begin
      e = exp_q.pop_front();
      chk({tag, " wr"}, {31'b0, w_regfile_wr_o}, {31'b0, e.wr});
      chk({tag, " misalign"}, {31'b0, misalign_o}, {31'b0, e.mis});
      if (e.wr) begin
        chk({tag, " waddr"}, {27'b0, w_regfile_waddr_o}, {27'b0, e.waddr});
        chk({tag, " wd"}, w_regfile_wd_o, e.wd);
      end
    end
  endtask

  initial begin
    // mem st  lop     sz     addr        rd            rdata         wa  rwr gd rv
    //   be     wdata         wd            wr mis stall req
    vecs.push_back(mk(1, 0, 3'b010, 2'b10, 32'h100, 32'h0, 32'hDEADBEEF, 5'd3, 1, 0, 0,
                      4'hF, 32'h0, 32'hDEADBEEF, 1, 0, 1, 1));
    vecs.push_back(mk(1, 0, 3'b000, 2'b00, 32'h103, 32'h0, 32'h80FFFFFF, 5'd4, 1, 0, 0,
                      4'h8, 32'h0, 32'hFFFFFF80, 1, 0, 1, 1));
    vecs.push_back(mk(1, 0, 3'b100, 2'b00, 32'h103, 32'h0, 32'h80FFFFFF, 5'd6, 1, 0, 0,
                      4'h8, 32'h0, 32'h00000080, 1, 0, 1, 1));
    vecs.push_back(mk(1, 1, 3'b000, 2'b01, 32'h202, 32'h1234ABCD, 32'h0, 5'd7, 1, 3, 0,
                      4'hC, 32'hABCDABCD, 32'h0, 0, 0, 3, 4));
    vecs.push_back(mk(0, 0, 3'b000, 2'b00, 32'h0, 32'h55, 32'h0, 5'd5, 1, 0, 0,
                      4'h0, 32'h0, 32'h55, 1, 0, 0, 0));
    vecs.push_back(mk(1, 0, 3'b001, 2'b01, 32'h102, 32'h0, 32'h80011234, 5'd8, 1, 1, 2,
                      4'hC, 32'h0, 32'hFFFF8001, 1, 0, 4, 2));
    vecs.push_back(mk(1, 0, 3'b101, 2'b01, 32'h100, 32'h0, 32'h1234F00D, 5'd9, 1, 0, 0,
                      4'h3, 32'h0, 32'h0000F00D, 1, 0, 1, 1));
    vecs.push_back(mk(1, 1, 3'b000, 2'b00, 32'h101, 32'hA5, 32'h0, 5'd10, 1, 0, 0,
                      4'h2, 32'hA5A5A5A5, 32'h0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 1, 3'b010, 2'b10, 32'h304, 32'hCAFEF00D, 32'h0, 5'd11, 0, 1, 0,
                      4'hF, 32'hCAFEF00D, 32'h0, 0, 0, 1, 2));
    vecs.push_back(mk(1, 0, 3'b100, 2'b00, 32'h001, 32'h0, 32'h00007F00, 5'd12, 1, 0, 1,
                      4'h2, 32'h0, 32'h0000007F, 1, 0, 2, 1));
    vecs.push_back(mk(1, 0, 3'b000, 2'b00, 32'h002, 32'h0, 32'h00FF0000, 5'd13, 1, 2, 0,
                      4'h4, 32'h0, 32'hFFFFFFFF, 1, 0, 3, 3));
    vecs.push_back(mk(0, 0, 3'b000, 2'b00, 32'h0, 32'h77, 32'h0, 5'd14, 0, 0, 0,
                      4'h0, 32'h0, 32'h77, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 3'b010, 2'b10, 32'h10C, 32'h0, 32'h01020304, 5'd15, 0, 0, 0,
                      4'hF, 32'h0, 32'h0, 0, 0, 1, 1));
`ifdef MEM_MISALIGN_CHECK_EN
    vecs.push_back(mk(1, 0, 3'b010, 2'b10, 32'h101, 32'h0, 32'hDEADBEEF, 5'd15, 1, 0, 0,
                      4'h0, 32'h0, 32'h0, 0, 1, 0, 0));
    vecs.push_back(mk(1, 1, 3'b000, 2'b01, 32'h201, 32'h1111, 32'h0, 5'd17, 1, 0, 0,
                      4'h0, 32'h0, 32'h0, 0, 1, 0, 0));
`else
    vecs.push_back(mk(1, 1, 3'b000, 2'b01, 32'h203, 32'h0000BEEF, 32'h0, 5'd17, 1, 0, 0,
                      4'hC, 32'hBEEFBEEF, 32'h0, 0, 0, 0, 1));
`endif
    vecs.push_back(mk(0, 0, 3'b000, 2'b00, 32'h0, 32'h99, 32'h0, 5'd16, 1, 0, 0,
                      4'h0, 32'h0, 32'h99, 1, 0, 0, 0));

    // Reset with a load already presented: no request, no stall, cleared outputs.
    rst_n = 1'b0;
    set_idle();
    apply(vecs[0]);
    #12;
    chk("reset req", {31'b0, data_req_o}, 32'd0);
    chk("reset stall", {31'b0, stall_mem_o}, 32'd0);
    chk("reset waddr", {27'b0, w_regfile_waddr_o}, 32'd0);
    chk("reset wd", w_regfile_wd_o, 32'd0);
    chk("reset wr", {31'b0, w_regfile_wr_o}, 32'd0);
    chk("reset misalign", {31'b0, misalign_o}, 32'd0);
    set_idle();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      run_instr($sformatf("vec%0d", i), vecs[i]);
    end

    // Reset while waiting for load data, then a late rvalid after release.
    apply(vecs[0]);
    data_gnt_i = 1'b1;
    @(negedge clk);
    chk("rstwait req", {31'b0, data_req_o}, 32'd1);
    @(posedge clk);
    #1;
    data_gnt_i = 1'b0;
    @(negedge clk);
    chk("rstwait stall_in_wait", {31'b0, stall_mem_o}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstwait stall_in_reset", {31'b0, stall_mem_o}, 32'd0);
    chk("rstwait req_in_reset", {31'b0, data_req_o}, 32'd0);
    chk("rstwait wr_in_reset", {31'b0, w_regfile_wr_o}, 32'd0);
    set_idle();
    @(posedge clk);
    #1;
    rst_n         = 1'b1;
    data_rvalid_i = 1'b1;
    data_rdata_i  = 32'h12345678;
    @(negedge clk);
    chk("rstwait late_rvalid_req", {31'b0, data_req_o}, 32'd0);
    chk("rstwait late_rvalid_stall", {31'b0, stall_mem_o}, 32'd0);
    @(posedge clk);
    #1;
    data_rvalid_i = 1'b0;
    chk("rstwait late_rvalid_wr", {31'b0, w_regfile_wr_o}, 32'd0);
    // A fresh load must run the full handshake from IDLE.
    run_instr("after_reset", vecs[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
